// File: rtl/proc_imul_iter_unit.sv
// Iterative shift-add multiplier returning the low p_nbits of op1*op2, one step per cycle.
// Optional early termination when the remaining multiplier bits are zero: PROC_IMUL_ITER_VARLAT_EN.
module proc_imul_iter_unit #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [2*p_nbits-1:0]   istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [p_nbits-1:0]     ostream_msg
);

  localparam int c_cw = $clog2(p_nbits);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [p_nbits-1:0] a_q, a_d;
  logic [p_nbits-1:0] b_q, b_d;
  logic [p_nbits-1:0] result_q, result_d;
  logic [c_cw-1:0]    counter_q, counter_d;
  logic               last_step;

`ifdef PROC_IMUL_ITER_VARLAT_EN
  // Stop once the shifted-out multiplier has no set bits left.
  assign last_step = (counter_q == c_cw'(p_nbits - 1)) || (b_q[p_nbits-1:1] == '0);
`else
  assign last_step = (counter_q == c_cw'(p_nbits - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      counter_q <= counter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        if (istream_val) begin
          a_d       = istream_msg[2*p_nbits-1:p_nbits];
          b_d       = istream_msg[p_nbits-1:0];
          result_d  = '0;
          counter_d = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (b_q[0]) result_d = result_q + a_q;
        a_d       = a_q << 1;
        b_d       = b_q >> 1;
        counter_d = counter_q + c_cw'(1);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign istream_rdy = (state_q == IDLE);
  assign ostream_val = (state_q == DONE);
  assign ostream_msg = result_q;

endmodule
